// File: rtl/signed_mac_neuron_if.sv
// Handshake bundle for the signed MAC neuron: control, input pair stream and result stream.
// The master drives start/bias/pairs/out_ready; the slave (the neuron) answers.
interface signed_mac_neuron_if;
    logic        start;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  w;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;

    modport master (
        output start, bias, in_valid, a, w, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, bias, in_valid, a, w, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/signed_mac_neuron.sv
// Sequential int8 multiply-accumulate neuron: bias-initialised accumulation of N_TERMS
// registered products, then arithmetic-shift requantisation, optional ReLU and int8 saturation.
module signed_mac_neuron #(
    parameter int N_TERMS = 16,
    parameter int ACC_W   = 24,
    parameter int SHIFT   = 7,
    parameter int RELU    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    signed_mac_neuron_if.slave   io_mac
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic signed [ACC_W-1:0] C_SAT_MAX = ACC_W'(32'sd127);
    localparam logic signed [ACC_W-1:0] C_SAT_MIN = ACC_W'(-32'sd128);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [15:0]       r_prod;
    logic                     r_prod_vld;
    logic [CNT_W-1:0]         r_count;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [7:0]               r_out_data;
    logic                     r_busy;

    logic                     w_hs;
    logic signed [15:0]       w_a_ext;
    logic signed [15:0]       w_w_ext;
    logic signed [15:0]       w_prod;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_final;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [7:0]               w_result;

    // ReLU (when enabled) followed by clamping to the int8 range
    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
        logic [7:0] res;
        if ((RELU != 0) && v[ACC_W-1]) begin
            res = 8'd0;
        end else if (v > C_SAT_MAX) begin
            res = 8'h7F;
        end else if (v < C_SAT_MIN) begin
            res = 8'h80;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

    // The 16-bit product of two int8 values is exact, so no widening beyond 16 bits is needed
    assign w_hs       = io_mac.in_valid & r_in_ready;
    assign w_a_ext    = {{8{io_mac.a[7]}}, io_mac.a};
    assign w_w_ext    = {{8{io_mac.w[7]}}, io_mac.w};
    assign w_prod     = w_a_ext * w_w_ext;
    assign w_bias_ext = {{(ACC_W-16){io_mac.bias[15]}}, io_mac.bias};
    assign w_prod_ext = {{(ACC_W-16){r_prod[15]}}, r_prod};
    assign w_final    = r_acc + w_prod_ext;
    assign w_shifted  = w_final >>> SHIFT;
    assign w_result   = sat8(w_shifted);

    assign io_mac.in_ready  = r_in_ready;
    assign io_mac.out_valid = r_out_valid;
    assign io_mac.out_data  = r_out_data;
    assign io_mac.busy      = r_busy;

    // Control FSM with accumulator, product pipeline register and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_prod      <= 16'sd0;
            r_prod_vld  <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_prod_vld <= 1'b0;
                    if (io_mac.start) begin
                        r_acc      <= w_bias_ext;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    // The product registered on the previous handshake joins the sum here
                    if (r_prod_vld) begin
                        r_acc <= w_final;
                    end
                    if (w_hs) begin
                        r_prod     <= w_prod;
                        r_prod_vld <= 1'b1;
                        r_count    <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(N_TERMS - 1)) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end else begin
                        r_prod_vld <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_acc       <= w_final;
                    r_prod_vld  <= 1'b0;
                    r_out_data  <= w_result;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (io_mac.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_prod_vld  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_mac_neuron.sv
// Bench for signed_mac_neuron: five differently parameterised instances share the pair stream,
// a transaction-level model predicts every handshake output, and literal pins anchor the model.
module tb_signed_mac_neuron;

    localparam int ND = 5;
    localparam int P_N  [0:4] = '{4, 4, 4, 1, 16};
    localparam int P_SH [0:4] = '{0, 7, 7, 7, 7};
    localparam int P_RL [0:4] = '{0, 0, 1, 0, 1};

    localparam int PH_IDLE = 0;
    localparam int PH_TAKE = 1;
    localparam int PH_FIN  = 2;
    localparam int PH_OUT  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [ND-1:0] start_v = '0;
    logic [ND-1:0] or_v    = '1;
    logic [15:0] bias     = 16'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  w = 8'd0;

    logic [ND-1:0]       ir_v;
    logic [ND-1:0]       ov_v;
    logic [ND-1:0]       bz_v;
    logic [ND-1:0][7:0]  od_v;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    int     m_ph  [ND] = '{default: 0};
    longint m_sum [ND] = '{default: 0};
    int     m_n   [ND] = '{default: 0};
    longint m_exp [ND] = '{default: 0};

    int pin_t0   [ND] = '{default: 0};
    int pin_lat  [ND] = '{default: 0};
    int pin_lit  [ND] = '{default: 0};
    int pin_req  [ND] = '{default: 0};
    int pin_done [ND] = '{default: 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        signed_mac_neuron_if u_if ();
        assign u_if.start     = start_v[g];
        assign u_if.bias      = bias;
        assign u_if.in_valid  = in_valid;
        assign u_if.a         = a;
        assign u_if.w         = w;
        assign u_if.out_ready = or_v[g];
        assign ir_v[g] = u_if.in_ready;
        assign ov_v[g] = u_if.out_valid;
        assign bz_v[g] = u_if.busy;
        assign od_v[g] = u_if.out_data;

        signed_mac_neuron #(
            .N_TERMS(P_N[g]), .ACC_W(24), .SHIFT(P_SH[g]), .RELU(P_RL[g])
        ) u_dut (
            .i_clk  (clk),
            .i_reset(rst),
            .io_mac (u_if)
        );
    end

    function automatic longint requant(input longint s, input int sh, input int relu);
        longint v;
        v = s >>> sh;
        if (relu != 0 && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level reference: what each neuron is doing and what it must eventually emit
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ND; k++) begin
                m_ph[k] = PH_IDLE;
                m_sum[k] = 0;
                m_n[k] = 0;
            end
        end else begin
            for (int k = 0; k < ND; k++) begin
                case (m_ph[k])
                    PH_IDLE: if (start_v[k]) begin
                        m_ph[k] = PH_TAKE;
                        m_sum[k] = longint'($signed(bias));
                        m_n[k] = 0;
                    end
                    PH_TAKE: if (in_valid) begin
                        m_sum[k] += longint'($signed(a)) * longint'($signed(w));
                        m_n[k]++;
                        if (m_n[k] == P_N[k]) m_ph[k] = PH_FIN;
                    end
                    PH_FIN: begin
                        m_exp[k] = requant(m_sum[k], P_SH[k], P_RL[k]);
                        m_ph[k] = PH_OUT;
                    end
                    PH_OUT: if (or_v[k]) m_ph[k] = PH_IDLE;
                    default: m_ph[k] = PH_IDLE;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input int k, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d cyc=%0d got=%0d expected=%0d", nm, k, cyc, got, exp);
        end
    endtask

    // Single compare process: model checks every cycle, reset literals, and timed literal pins
    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            chk("busy", k, longint'(bz_v[k]), longint'(m_ph[k] != PH_IDLE));
            chk("in_ready", k, longint'(ir_v[k]), longint'(m_ph[k] == PH_TAKE));
            chk("out_valid", k, longint'(ov_v[k]), longint'(m_ph[k] == PH_OUT));
            if (m_ph[k] == PH_OUT) chk("out_data", k, longint'($signed(od_v[k])), m_exp[k]);
            if (rst) begin
                chk("rst_in_ready", k, longint'(ir_v[k]), 0);
                chk("rst_out_valid", k, longint'(ov_v[k]), 0);
                chk("rst_busy", k, longint'(bz_v[k]), 0);
                chk("rst_out_data", k, longint'(od_v[k]), 0);
            end
            if (pin_req[k] != pin_done[k] && cyc == pin_t0[k] + pin_lat[k]) begin
                chk("pin_out_valid", k, longint'(ov_v[k]), 1);
                chk("pin_out_data", k, longint'($signed(od_v[k])), longint'(pin_lit[k]));
                chk("pin_model", k, m_exp[k], longint'(pin_lit[k]));
                pin_done[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input int k, input int lit, input int lat);
        pin_t0[k] = cyc;
        pin_lat[k] = lat;
        pin_lit[k] = lit;
        pin_req[k]++;
    endtask

    task automatic go(input logic [ND-1:0] mask, input int b);
        start_v = mask;
        bias = b[15:0];
        tick();
        start_v = '0;
    endtask

    task automatic feed(input int ai, input int wi);
        in_valid = 1'b1;
        a = ai[7:0];
        w = wi[7:0];
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int pat [0:6];
        pat = '{1, 0, 0, 1, 1, 0, 1};
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic sum 1+2+3+4 with unit weights
        pin(0, 10, 6);
        go(5'b00001, 0);
        for (int i = 1; i <= 4; i++) feed(i, 1);
        repeat (4) tick();

        // Positive saturation: 4 * 16384 >>> 7 = 512
        pin(1, 127, 6); pin(2, 127, 6);
        go(5'b00110, 0);
        repeat (4) feed(-128, -128);
        repeat (4) tick();

        // Negative saturation: 4 * -16256 >>> 7 = -508
        pin(1, -128, 6); pin(2, 0, 6);
        go(5'b00110, 0);
        repeat (4) feed(-128, 127);
        repeat (4) tick();

        // Floor rounding of the arithmetic shift
        pin(3, -1, 3);
        go(5'b01000, -1);
        feed(0, 5);
        repeat (4) tick();
        pin(3, 2, 3);
        go(5'b01000, 300);
        feed(0, 0);
        repeat (4) tick();

        // Input gaps, a stray start while accumulating and while presenting, and backpressure
        or_v[0] = 1'b0;
        pin(0, 24, 9);
        go(5'b00001, 0);
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i][0];
            a = 8'd2;
            w = 8'd3;
            start_v = (i == 2) ? 5'b00001 : 5'b00000;
            tick();
        end
        in_valid = 1'b0;
        start_v = '0;
        tick();
        start_v = 5'b00001;
        tick();
        start_v = '0;
        repeat (4) tick();
        or_v[0] = 1'b1;
        repeat (4) tick();

        // Reset in the middle of accumulation, then a fresh transaction
        go(5'b10001, 0);
        repeat (3) feed(5, 5);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        pin(0, 25, 6);
        go(5'b00001, 5);
        for (int i = 1; i <= 4; i++) feed(i, 2);
        repeat (4) tick();

        // Randomised traffic across all instances
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0;
            for (int k = 0; k < ND; k++) begin
                start_v[k] = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
                or_v[k] = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            end
            bias = 16'($urandom);
            in_valid = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            a = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
            w = ($urandom_range(0, 7) == 0) ? 8'h7F : 8'($urandom);
            tick();
        end
        rst = 1'b0;
        start_v = '0;
        in_valid = 1'b0;
        or_v = '1;
        repeat (40) tick();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_mac_neuron.md
# signed_mac_neuron

Sequential signed multiply-accumulate neuron stage consuming int8 activation/weight pairs, which are the operands of the signed 8x8 multiply stage. It streams N_TERMS pairs over a valid/ready handshake and registers each 16-bit signed product. Products accumulate into a bias-initialised wide accumulator. The block then requantises the sum by arithmetic shift, applies optional ReLU, saturates to int8 and presents the result on a valid/ready output port for the next layer.

## Interface
- N_TERMS, 16, number of pairs per dot product (>=1)
- ACC_W, 24, accumulator width; must be >= 17 + clog2(N_TERMS)
- SHIFT, 7, arithmetic right shift applied to the final sum (0..ACC_W-1)
- RELU, 1, 1 = clamp negative results to 0; 0 = pass signed
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a dot product; sampled only in IDLE
- bias  in  16  signed bias, sampled with start, sign-extended to ACC_W
- in_valid  in  1  pair (a, w) valid
- in_ready  out  1  block accepts a pair this cycle
- a  in  8  signed activation
- w  in  8  signed weight
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  8  signed int8 result
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCUM, DRAIN, OUTPUT.
- IDLE: on start=1, load acc <= sext(bias), count <= 0, prod_vld <= 0, go ACCUM.
- ACCUM: in_ready = 1. On a handshake (in_valid & in_ready), register prod <= $signed(a)*$signed(w) (16-bit, exact), prod_vld <= 1, count++. With no handshake, prod_vld <= 0.
  - Each edge with prod_vld=1 adds sext(prod) to acc.
  - On the N_TERMS-th handshake, go DRAIN.
- DRAIN: in_ready = 0. Compute final = acc + sext(prod). Register out_data <= sat8(relu(final >>> SHIFT)) and out_valid <= 1. Go OUTPUT.
- OUTPUT: hold out_data and out_valid until out_ready=1. On that edge, out_valid <= 0 and the state goes to IDLE.
- Arithmetic: shift is arithmetic, so it rounds toward negative infinity. ReLU, when enabled, maps negative values to 0. sat8 clamps to [-128, 127].
- A start asserted outside IDLE is ignored. in_valid outside ACCUM is ignored, because in_ready = 0 there.
- If ACC_W violates its bound, the accumulator wraps two's-complement; results are unspecified.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0. Internal state: acc=0, count=0, prod_vld=0, state=IDLE.
- Reset asserted at any time, including mid-accumulation or while out_valid is high, returns everything to reset values immediately. No partial result is emitted.
- start in cycle 0 → in_ready=1 and busy=1 from cycle 1.
- A back-to-back stream is accepted in cycles 1..N_TERMS, with in_ready deasserting after the last handshake. out_valid rises in cycle N_TERMS+2.
- General case: last handshake in cycle c → out_valid high in cycle c+2.
- Gaps in in_valid stall the block without corrupting the sum.
- With out_ready held high, out_valid is high for exactly one cycle and busy drops the next cycle. The next start is accepted in the cycle after out_valid falls.
- out_data is stable for the whole time out_valid is high.

## Test plan
- Reset: assert reset mid-stream → next cycle in_ready=0, out_valid=0, out_data=0, busy=0. A new start then produces a correct fresh result.
- Basic (N_TERMS=4, SHIFT=0, RELU=0, bias=0): a=1,2,3,4, w=1 back-to-back from cycle 1 → out_data=10, out_valid in cycle 6.
- Positive saturation (N_TERMS=4, SHIFT=7): a=w=-128 four times (sum 65536, >>>7 = 512) → out_data=127.
- Negative saturation (same parameters): a=-128, w=127 four times (sum -65024, >>>7 = -508) → out_data=-128 with RELU=0, 0 with RELU=1.
- Floor rounding (N_TERMS=1, SHIFT=7, RELU=0): bias=-1, a=0, w=5 → out_data=-1. bias=300, a=0, w=0 → out_data=2.
- Stalls and backpressure:
  - Stimulus: N_TERMS=4, SHIFT=0, RELU=0, bias=0. in_valid toggles 1,0,0,1,1,0,1 with a=2, w=3 on each valid beat. out_ready is held low 5 cycles after out_valid rises. start is pulsed while busy.
  - Response: out_data=24, held stable through the stall. The extra start is ignored. Exactly one result is produced.
